// File: rtl/i2c_slave_regwr.sv
// ---------------------------------------------------------------------------
// i2c_slave_regwr
// Write-only I2C slave. SCL/SDA are oversampled by clk_sda; the block decodes
// START, device address, register pointer and data bytes. Each data byte
// becomes a one-cycle register-file write strobe. ACK is driven through an
// open-drain enable.
//
// Optional feature macro: I2C_SLV_AUTOINC_EN
//   defined     : pointer increments (8'hFF wraps to 8'h00) after each write
//   not defined : pointer stays fixed after the register-address byte
//
// Ports:
//   clk_sda      in   system clock (>= 8x SCL frequency)
//   rst_n        in   asynchronous active-low reset
//   i2c_scl      in   I2C clock line (asynchronous)
//   i2c_sda      in   I2C data line as seen on the bus
//   i2c_sda_oe   out  1 pulls SDA low (ACK), 0 releases it
//   reg_wr_en    out  one-cycle write strobe
//   reg_wr_addr  out  write address, valid with reg_wr_en
//   reg_wr_data  out  write data, valid with reg_wr_en
//   busy         out  1 from START to STOP
// ---------------------------------------------------------------------------
module i2c_slave_regwr #(
    parameter logic [6:0] DEV_ADDR = 7'h0A
) (
    input  logic       clk_sda,
    input  logic       rst_n,
    input  logic       i2c_scl,
    input  logic       i2c_sda,
    output logic       i2c_sda_oe,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEVADDR = 3'd1,
        ST_DEVACK  = 3'd2,
        ST_REGADDR = 3'd3,
        ST_REGACK  = 3'd4,
        ST_DATA    = 3'd5,
        ST_DATAACK = 3'd6,
        ST_IGNORE  = 3'd7
    } state_t;

    // A received address byte is ours only when it carries our address and a write request.
    function automatic logic addr_is_write_match(input logic [7:0] addr_byte);
        addr_is_write_match = (addr_byte[7:1] == DEV_ADDR) && (addr_byte[0] == 1'b0);
    endfunction

    // Synchronizer and history flops; idle bus level is high, so reset to 1 to avoid fake edges.
    logic scl_s1_r, scl_s2_r, scl_d_r;
    logic sda_s1_r, sda_s2_r, sda_d_r;

    state_t     state_r, state_nx;
    logic [7:0] shift_r;
    logic [2:0] bit_cnt_r;
    logic       full_r;
    logic [7:0] ptr_r;
    logic       sda_oe_r, wr_en_r, busy_r;
    logic [7:0] wr_addr_r, wr_data_r;

    logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s;
    logic shift_en_s, clr_bits_s, wr_s, ptr_load_s;

    // Two-flop synchronizers plus one history flop per line.
    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_r <= 1'b1;
            scl_s2_r <= 1'b1;
            scl_d_r  <= 1'b1;
            sda_s1_r <= 1'b1;
            sda_s2_r <= 1'b1;
            sda_d_r  <= 1'b1;
        end else begin
            scl_s1_r <= i2c_scl;
            scl_s2_r <= scl_s1_r;
            scl_d_r  <= scl_s2_r;
            sda_s1_r <= i2c_sda;
            sda_s2_r <= sda_s1_r;
            sda_d_r  <= sda_s2_r;
        end
    end

    assign scl_rise_s  = scl_s2_r & ~scl_d_r;
    assign scl_fall_s  = ~scl_s2_r & scl_d_r;
    // SCL must be high in both samples so an SDA change near an SCL edge is not misread.
    assign start_det_s = scl_s2_r & scl_d_r & sda_d_r & ~sda_s2_r;
    assign stop_det_s  = scl_s2_r & scl_d_r & ~sda_d_r & sda_s2_r;

    // FSM state register.
    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state and per-cycle control decode; bus conditions outrank bit sampling.
    always_comb begin
        state_nx   = state_r;
        shift_en_s = 1'b0;
        clr_bits_s = 1'b0;
        wr_s       = 1'b0;
        ptr_load_s = 1'b0;
        if (stop_det_s) begin
            state_nx   = ST_IDLE;
            clr_bits_s = 1'b1;
        end else if (start_det_s) begin
            state_nx   = ST_DEVADDR;
            clr_bits_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx = ST_IDLE;
                end
                ST_DEVADDR: begin
                    if (scl_rise_s) begin
                        shift_en_s = 1'b1;
                    end else if (scl_fall_s && full_r) begin
                        clr_bits_s = 1'b1;
                        if (addr_is_write_match(shift_r)) begin
                            state_nx = ST_DEVACK;
                        end else begin
                            state_nx = ST_IGNORE;
                        end
                    end else begin
                        state_nx = ST_DEVADDR;
                    end
                end
                ST_REGADDR: begin
                    if (scl_rise_s) begin
                        shift_en_s = 1'b1;
                    end else if (scl_fall_s && full_r) begin
                        clr_bits_s = 1'b1;
                        ptr_load_s = 1'b1;
                        state_nx   = ST_REGACK;
                    end else begin
                        state_nx = ST_REGADDR;
                    end
                end
                ST_DATA: begin
                    if (scl_rise_s) begin
                        shift_en_s = 1'b1;
                    end else if (scl_fall_s && full_r) begin
                        clr_bits_s = 1'b1;
                        wr_s       = 1'b1;
                        state_nx   = ST_DATAACK;
                    end else begin
                        state_nx = ST_DATA;
                    end
                end
                // ACK windows close on the SCL falling edge that ends the ninth clock.
                ST_DEVACK: begin
                    if (scl_fall_s) begin
                        state_nx = ST_REGADDR;
                    end else begin
                        state_nx = ST_DEVACK;
                    end
                end
                ST_REGACK: begin
                    if (scl_fall_s) begin
                        state_nx = ST_DATA;
                    end else begin
                        state_nx = ST_REGACK;
                    end
                end
                ST_DATAACK: begin
                    if (scl_fall_s) begin
                        state_nx = ST_DATA;
                    end else begin
                        state_nx = ST_DATAACK;
                    end
                end
                ST_IGNORE: begin
                    state_nx = ST_IGNORE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // Shift register and bit counter; full_r marks that all eight bits are in.
    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            full_r    <= 1'b0;
        end else if (clr_bits_s) begin
            bit_cnt_r <= 3'd0;
            full_r    <= 1'b0;
        end else if (shift_en_s) begin
            shift_r   <= {shift_r[6:0], sda_s2_r};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
                full_r <= 1'b1;
            end
        end
    end

    // Register pointer: loaded by the register-address byte, optionally advanced per write.
    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 8'h00;
        end else if (ptr_load_s) begin
            ptr_r <= shift_r;
`ifdef I2C_SLV_AUTOINC_EN
        end else if (wr_s) begin
            ptr_r <= ptr_r + 8'd1;
`else
        end else begin
            ptr_r <= ptr_r;
`endif
        end
    end

    // Registered outputs; ACK enable follows the ACK states, so it drops with STOP/START too.
    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe_r  <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= 8'h00;
            wr_data_r <= 8'h00;
            busy_r    <= 1'b0;
        end else begin
            sda_oe_r <= (state_nx == ST_DEVACK) || (state_nx == ST_REGACK) ||
                        (state_nx == ST_DATAACK);
            wr_en_r  <= wr_s;
            busy_r   <= (state_nx != ST_IDLE);
            if (wr_s) begin
                wr_addr_r <= ptr_r;
                wr_data_r <= shift_r;
            end
        end
    end

    assign i2c_sda_oe  = sda_oe_r;
    assign reg_wr_en   = wr_en_r;
    assign reg_wr_addr = wr_addr_r;
    assign reg_wr_data = wr_data_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_i2c_slave_regwr.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regwr
// Directed bench for i2c_slave_regwr: a simple bus master drives SCL/SDA
// (SCL low and high phases of 8 clk_sda cycles each), SDA is modelled as
// wired-AND of master and slave. A monitor logs write strobes and ACK-enable
// activity; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_i2c_slave_regwr;

    logic       clk_sda = 1'b0;
    logic       rst_n   = 1'b0;
    logic       i2c_scl = 1'b1;
    logic       m_sda   = 1'b1;
    logic       i2c_sda;
    logic       i2c_sda_oe;
    logic       reg_wr_en;
    logic [7:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] wr_q[$];
    int          dbl_cnt = 0;
    int          oe_cnt  = 0;
    logic        prev_wr = 1'b0;

    assign i2c_sda = m_sda & ~i2c_sda_oe;

    i2c_slave_regwr #(.DEV_ADDR(7'h0A)) dut (
        .clk_sda    (clk_sda),
        .rst_n      (rst_n),
        .i2c_scl    (i2c_scl),
        .i2c_sda    (i2c_sda),
        .i2c_sda_oe (i2c_sda_oe),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .busy       (busy)
    );

    always #5 clk_sda = ~clk_sda;

    // Monitor: log strobes, back-to-back strobes and ACK-enable cycles.
    always @(negedge clk_sda) begin
        if (reg_wr_en) begin
            wr_q.push_back({reg_wr_addr, reg_wr_data});
            if (prev_wr) dbl_cnt = dbl_cnt + 1;
        end
        prev_wr = reg_wr_en;
        if (i2c_sda_oe) oe_cnt = oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sda);
    endtask

    task automatic bus_start();
        if (i2c_scl == 1'b0) begin
            m_sda = 1'b1;
            wait_cyc(4);
            i2c_scl = 1'b1;
            wait_cyc(8);
        end
        m_sda = 1'b0;
        wait_cyc(8);
        i2c_scl = 1'b0;
        wait_cyc(4);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        wait_cyc(4);
        i2c_scl = 1'b1;
        wait_cyc(8);
        m_sda = 1'b1;
        wait_cyc(8);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;
        wait_cyc(4);
        i2c_scl = 1'b1;
        wait_cyc(8);
        i2c_scl = 1'b0;
        wait_cyc(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1;
        wait_cyc(4);
        i2c_scl = 1'b1;
        wait_cyc(4);
        ack = i2c_sda_oe & ~i2c_sda;
        wait_cyc(4);
        i2c_scl = 1'b0;
        wait_cyc(4);
    endtask

    initial begin
        logic ack;
        int   base;
        int   oe_base;

        // Reset state
        wait_cyc(3);
        check("rst_oe",   {31'd0, i2c_sda_oe}, 32'd0);
        check("rst_wren", {31'd0, reg_wr_en},  32'd0);
        check("rst_addr", {24'd0, reg_wr_addr}, 32'h00);
        check("rst_data", {24'd0, reg_wr_data}, 32'h00);
        check("rst_busy", {31'd0, busy},       32'd0);
        rst_n = 1'b1;
        wait_cyc(8);

        // Basic write 0x05 <= 0x50
        base = wr_q.size();
        bus_start();
        check("t1_busy_start", {31'd0, busy}, 32'd1);
        send_byte(8'h14, ack); check("t1_ack_dev", {31'd0, ack}, 32'd1);
        send_byte(8'h05, ack); check("t1_ack_reg", {31'd0, ack}, 32'd1);
        send_byte(8'h50, ack); check("t1_ack_dat", {31'd0, ack}, 32'd1);
        bus_stop();
        check("t1_nwr", wr_q.size() - base, 32'd1);
        if (wr_q.size() > base) check("t1_wr0", {16'd0, wr_q[base]}, 32'h0550);
        check("t1_busy_stop", {31'd0, busy}, 32'd0);
        check("t1_oe_stop",   {31'd0, i2c_sda_oe}, 32'd0);

        // Wrong address 0x0B
        base = wr_q.size(); oe_base = oe_cnt;
        bus_start();
        send_byte(8'h16, ack); check("t2_nack_dev", {31'd0, ack}, 32'd0);
        send_byte(8'h05, ack); check("t2_nack_b1", {31'd0, ack}, 32'd0);
        send_byte(8'h48, ack); check("t2_nack_b2", {31'd0, ack}, 32'd0);
        bus_stop();
        check("t2_nwr", wr_q.size() - base, 32'd0);
        check("t2_oe_cycles", oe_cnt - oe_base, 32'd0);

        // Read request 0x0A+R
        base = wr_q.size(); oe_base = oe_cnt;
        bus_start();
        send_byte(8'h15, ack); check("t3_nack_dev", {31'd0, ack}, 32'd0);
        send_byte(8'h33, ack); check("t3_nack_b1", {31'd0, ack}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd1);
        bus_stop();
        check("t3_nwr", wr_q.size() - base, 32'd0);
        check("t3_oe_cycles", oe_cnt - oe_base, 32'd0);

        // Multi-byte write starting at 0xFF
        base = wr_q.size();
        bus_start();
        send_byte(8'h14, ack);
        send_byte(8'hFF, ack);
        send_byte(8'h50, ack); check("t4_ack1", {31'd0, ack}, 32'd1);
        send_byte(8'h48, ack); check("t4_ack2", {31'd0, ack}, 32'd1);
        send_byte(8'h53, ack); check("t4_ack3", {31'd0, ack}, 32'd1);
        bus_stop();
        check("t4_nwr", wr_q.size() - base, 32'd3);
        if (wr_q.size() >= base + 3) begin
            check("t4_wr0", {16'd0, wr_q[base]}, 32'hFF50);
`ifdef I2C_SLV_AUTOINC_EN
            check("t4_wr1", {16'd0, wr_q[base+1]}, 32'h0048);
            check("t4_wr2", {16'd0, wr_q[base+2]}, 32'h0153);
`else
            check("t4_wr1", {16'd0, wr_q[base+1]}, 32'hFF48);
            check("t4_wr2", {16'd0, wr_q[base+2]}, 32'hFF53);
`endif
        end

        // STOP after 4 data bits, then a fresh transaction
        base = wr_q.size();
        bus_start();
        send_byte(8'h14, ack);
        send_byte(8'h05, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop();
        check("t5_nwr_partial", wr_q.size() - base, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        bus_start();
        send_byte(8'h14, ack);
        send_byte(8'h06, ack);
        send_byte(8'h4E, ack); check("t5_ack", {31'd0, ack}, 32'd1);
        bus_stop();
        check("t5_nwr", wr_q.size() - base, 32'd1);
        if (wr_q.size() > base) check("t5_wr0", {16'd0, wr_q[base]}, 32'h064E);

        // Reset during REGADDR bit 3
        bus_start();
        send_byte(8'h14, ack);
        send_bit(1'b0); send_bit(1'b0);
        m_sda = 1'b1;
        wait_cyc(4);
        i2c_scl = 1'b1;
        wait_cyc(4);
        check("t6_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_addr", {24'd0, reg_wr_addr}, 32'h00);
        check("t6_rst_data", {24'd0, reg_wr_data}, 32'h00);
        check("t6_rst_oe",   {31'd0, i2c_sda_oe}, 32'd0);
        wait_cyc(4);
        i2c_scl = 1'b0;
        wait_cyc(4);
        i2c_scl = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(8);
        check("t6_idle_busy", {31'd0, busy}, 32'd0);
        base = wr_q.size();
        bus_start();
        send_byte(8'h14, ack);
        send_byte(8'h04, ack);
        send_byte(8'h58, ack);
        bus_stop();
        check("t6_nwr", wr_q.size() - base, 32'd1);
        if (wr_q.size() > base) check("t6_wr0", {16'd0, wr_q[base]}, 32'h0458);

        check("dbl_strobe", dbl_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
